// File: rtl/syn_i2c_slave.sv
// I2C responder: synchronizes SCL/SDA, decodes START/STOP, matches a 7-bit address
// and serves a byte-wide register bank through a pointer-based write/read protocol.
module syn_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         DEPTH      = 16,
    localparam int        PTR_W      = $clog2(DEPTH)
) (
    input  logic             clk_ir,
    input  logic             rst_il,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             release_sda,
    output logic             wr_valid_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] lcl_raddr_i,
    output logic [7:0]       lcl_rdata_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    // [0] metastable stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0]       r_scl_sync;
    logic [2:0]       r_sda_sync;
    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [PTR_W-1:0] r_ptr;
    logic             r_rw;
    logic             r_ack_ph;
    logic             r_release;
    logic             r_wr_valid;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_regs [DEPTH];

    logic             w_scl;
    logic             w_sda;
    logic             w_scl_rise;
    logic             w_scl_fall;
    logic             w_start;
    logic             w_stop;
    logic [7:0]       w_byte;
    logic             w_last_bit;

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_sync[2];
    assign w_scl_fall = ~w_scl & r_scl_sync[2];
    assign w_start    = w_scl & r_scl_sync[2] & ~w_sda & r_sda_sync[2];
    assign w_stop     = w_scl & r_scl_sync[2] & w_sda & ~r_sda_sync[2];
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    assign sda_o       = 1'b0;
    assign release_sda = r_release;
    assign wr_valid_o  = r_wr_valid;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign lcl_rdata_o = r_regs[lcl_raddr_i];

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl_i};
            r_sda_sync <= {r_sda_sync[1:0], sda_i};
        end
    end

    // Protocol FSM, register bank and registered bus/write-port outputs
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_ack_ph   <= 1'b0;
            r_release  <= 1'b1;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_ack_ph  <= 1'b0;
                r_release <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_ack_ph  <= 1'b0;
                r_release <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_release <= 1'b1;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (w_last_bit) begin
                                r_bit_cnt <= 3'd0;
                                r_rw      <= w_sda;
                                r_state   <= (w_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (w_last_bit) begin
                                r_bit_cnt <= 3'd0;
                                r_ptr     <= w_byte[PTR_W-1:0];
                                r_state   <= S_PTR_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (w_last_bit) begin
                                r_bit_cnt     <= 3'd0;
                                r_regs[r_ptr] <= w_byte;
                                r_wr_valid    <= 1'b1;
                                r_wr_addr     <= r_ptr;
                                r_wr_data     <= w_byte;
                                r_ptr         <= r_ptr + 1'b1;
                                r_state       <= S_WDATA_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    // First fall pulls SDA low for the ACK slot, second fall ends it
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                r_ack_ph  <= 1'b1;
                                r_release <= 1'b0;
                            end else begin
                                r_ack_ph  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_shift   <= r_regs[r_ptr];
                                    r_release <= r_regs[r_ptr][7];
                                    r_state   <= S_RDATA;
                                end else begin
                                    r_release <= 1'b1;
                                    r_state   <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (w_last_bit) begin
                                r_bit_cnt <= 3'd0;
                                r_release <= 1'b1;
                                r_ptr     <= r_ptr + 1'b1;
                                r_state   <= S_RDATA_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_release <= r_shift[6];
                            end
                        end
                    end
                    // r_ack_ph remembers a master ACK until the fall that starts the next byte
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_ack_ph <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_ack_ph  <= 1'b0;
                            r_shift   <= r_regs[r_ptr];
                            r_release <= r_regs[r_ptr][7];
                            r_state   <= S_RDATA;
                        end
                    end
                    S_WAIT_STOP: begin
                        r_release <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_release <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
